sd_cmd_sequencer: RTL and testbench

Sequences one SD command transaction end to end on the CMD line. It captures a host request, starts the command transmitter, and enables the response receiver with the correct response-type strobes. It also enforces the response timeout and the post-response gap, and reports response data and status to the host. It sits between the host register interface and the existing command transmitter / `sd_receive` pair, in the `sd_clk` domain.

---
 rtl/sd_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - SD CMD-line command transaction sequencer
//
// Purpose: runs one SD command transaction from start to finish. It
// captures a host request, starts the command transmitter, and arms the
// response receiver. It enforces the NCR response timeout and the NCC gap
// after each transaction, then reports the response and status to the host.
//
// Optional feature macro: SD_CMD_RETRY_EN
//   defined   - a CRC error or timeout retries the command up to MAX_RETRY
//               extra times; attempts reports 0..MAX_RETRY.
//   undefined - single attempt only; attempts is tied to 0.
//
// Ports:
//   sd_clk, reset          clock, asynchronous active-low reset
//   req_*                  host request handshake: index, argument, response type
//   tx_start/tx_index/tx_arg/tx_done
//                          command transmitter control
//   receive_en/R2_response/R3_response/rx_started/rx_finished/crc_err/
//   rx_response/rx_abort   response receiver control and result
//   busy/done/status/resp_data/attempts
//                          host-side transaction result
module sd_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned GAP_CYCLES     = 8,
   parameter int unsigned MAX_RETRY      = 2
) (
   input  logic         sd_clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [5:0]   req_index,
   input  logic [31:0]  req_arg,
   input  logic [1:0]   req_resp_type,
   output logic         tx_start,
   output logic [5:0]   tx_index,
   output logic [31:0]  tx_arg,
   input  logic         tx_done,
   output logic         receive_en,
   output logic         R2_response,
   output logic         R3_response,
   input  logic         rx_started,
   input  logic         rx_finished,
   input  logic         crc_err,
   input  logic [126:0] rx_response,
   output logic         rx_abort,
   output logic         busy,
   output logic         done,
   output logic [1:0]   status,
   output logic [126:0] resp_data,
   output logic [1:0]   attempts
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_SEND       = 3'd1;
   localparam logic [2:0] S_WAIT_TX    = 3'd2;
   localparam logic [2:0] S_WAIT_START = 3'd3;
   localparam logic [2:0] S_RECEIVE    = 3'd4;
   localparam logic [2:0] S_RETRY      = 3'd5;
   localparam logic [2:0] S_DONE       = 3'd6;
   localparam logic [2:0] S_GAP        = 3'd7;

`ifdef SD_CMD_RETRY_EN
   localparam logic RETRY_EN = 1'b1;
`else
   localparam logic RETRY_EN = 1'b0;
`endif

   // The timeout counter holds (WAIT_START cycle number - 1). The last
   // allowed cycle therefore shows TIMEOUT_CYCLES-1.
   localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);
   localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

   logic [2:0]   state_q, state_d;
   logic [1:0]   type_q, type_d;
   logic [5:0]   tx_index_q, tx_index_d;
   logic [31:0]  tx_arg_q, tx_arg_d;
   logic [7:0]   tmo_q, tmo_d;
   logic [3:0]   gap_q, gap_d;
   logic [1:0]   retry_q, retry_d;
   logic [1:0]   result_q, result_d;
   logic [1:0]   status_q, status_d;
   logic [126:0] resp_data_q, resp_data_d;
   logic [1:0]   attempts_q, attempts_d;
   logic         done_q, done_d;
   logic         timeout;

   assign timeout = (tmo_q >= TMO_LAST);

   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      tx_index_d  = tx_index_q;
      tx_arg_d    = tx_arg_q;
      tmo_d       = tmo_q;
      gap_d       = gap_q;
      retry_d     = retry_q;
      result_d    = result_q;
      status_d    = status_q;
      resp_data_d = resp_data_q;
      attempts_d  = attempts_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               type_d     = req_resp_type;
               tx_index_d = req_index;
               tx_arg_d   = req_arg;
               retry_d    = 2'd0;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            state_d = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (tx_done) begin
               if (type_q == 2'd0) begin
                  result_d = 2'b00;
                  state_d  = S_DONE;
               end else begin
                  tmo_d   = 8'd0;
                  state_d = S_WAIT_START;
               end
            end
         end
         S_WAIT_START: begin
            tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
            // A start bit on the final allowed cycle still counts.
            if (rx_started) begin
               state_d = S_RECEIVE;
            end else if (timeout) begin
               result_d = 2'b10;
               state_d  = S_RETRY;
            end
         end
         S_RECEIVE: begin
            if (rx_finished) begin
               resp_data_d = rx_response;
               // R3 carries no valid CRC, so its check result is ignored.
               if (crc_err && (type_q != 2'd3)) begin
                  result_d = 2'b01;
                  state_d  = S_RETRY;
               end else begin
                  result_d = 2'b00;
                  state_d  = S_DONE;
               end
            end
         end
         S_RETRY: begin
            if (RETRY_EN && (retry_q < RETRY_LIMIT)) begin
               retry_d = retry_q + 2'd1;
               state_d = S_SEND;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // done, status and attempts are registered here, so they appear
            // together one cycle later.
            done_d     = 1'b1;
            status_d   = result_q;
            attempts_d = RETRY_EN ? retry_q : 2'd0;
            gap_d      = 4'd0;
            state_d    = S_GAP;
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sd_clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         type_q      <= 2'd0;
         tx_index_q  <= 6'd0;
         tx_arg_q    <= 32'd0;
         tmo_q       <= 8'd0;
         gap_q       <= 4'd0;
         retry_q     <= 2'd0;
         result_q    <= 2'd0;
         status_q    <= 2'd0;
         resp_data_q <= '0;
         attempts_q  <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         tx_index_q  <= tx_index_d;
         tx_arg_q    <= tx_arg_d;
         tmo_q       <= tmo_d;
         gap_q       <= gap_d;
         retry_q     <= retry_d;
         result_q    <= result_d;
         status_q    <= status_d;
         resp_data_q <= resp_data_d;
         attempts_q  <= attempts_d;
         done_q      <= done_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign tx_start    = (state_q == S_SEND);
   assign receive_en  = (state_q == S_WAIT_START) || (state_q == S_RECEIVE);
   assign rx_abort    = (state_q == S_WAIT_START) && !rx_started && timeout;
   assign R2_response = busy && (type_q == 2'd2);
   assign R3_response = busy && (type_q == 2'd3);
   assign tx_index    = tx_index_q;
   assign tx_arg      = tx_arg_q;
   assign done        = done_q;
   assign status      = status_q;
   assign resp_data   = resp_data_q;
   assign attempts    = attempts_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - self-checking bench for sd_cmd_sequencer
module tb_sd_cmd_sequencer;

   localparam int TMO    = 64;
   localparam int GAP    = 8;
   localparam int TX_LAT = 3;
   localparam int RX_LEN = 5;

   logic         sd_clk = 1'b0;
   logic         reset = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [5:0]   req_index = '0;
   logic [31:0]  req_arg = '0;
   logic [1:0]   req_resp_type = '0;
   logic         tx_start;
   logic [5:0]   tx_index;
   logic [31:0]  tx_arg;
   logic         tx_done = 1'b0;
   logic         receive_en;
   logic         R2_response;
   logic         R3_response;
   logic         rx_started = 1'b0;
   logic         rx_finished = 1'b0;
   logic         crc_err = 1'b0;
   logic [126:0] rx_response = '0;
   logic         rx_abort;
   logic         busy;
   logic         done;
   logic [1:0]   status;
   logic [126:0] resp_data;
   logic [1:0]   attempts;

   sd_cmd_sequencer #(
      .TIMEOUT_CYCLES(TMO),
      .GAP_CYCLES    (GAP),
      .MAX_RETRY     (2)
   ) dut (
      .sd_clk       (sd_clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_index    (req_index),
      .req_arg      (req_arg),
      .req_resp_type(req_resp_type),
      .tx_start     (tx_start),
      .tx_index     (tx_index),
      .tx_arg       (tx_arg),
      .tx_done      (tx_done),
      .receive_en   (receive_en),
      .R2_response  (R2_response),
      .R3_response  (R3_response),
      .rx_started   (rx_started),
      .rx_finished  (rx_finished),
      .crc_err      (crc_err),
      .rx_response  (rx_response),
      .rx_abort     (rx_abort),
      .busy         (busy),
      .done         (done),
      .status       (status),
      .resp_data    (resp_data),
      .attempts     (attempts)
   );

   always #5 sd_clk = ~sd_clk;

   typedef struct {
      logic [1:0]  rtype;
      logic [5:0]  index;
      logic [31:0] arg;
      int          start;
      logic [3:0]  crc;
      logic [1:0]  st;
      logic [1:0]  att;
      int          ntx;
      int          nabort;
      int          lat;
      bit          norecv;
   } vec_t;

   vec_t vecs[8];
   vec_t sb[$];

   int           n_checks = 0;
   int           n_fail = 0;
   int           cfg_start = 0;
   logic [3:0]   cfg_crc = '0;
   bit           in_rx = 0;
   int           done_cnt = 0;
   logic [126:0] model_resp = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_ctl"},
            128'({req_ready, tx_start, receive_en, R2_response, R3_response,
                  rx_abort, busy, done, status, attempts}),
            128'(12'h800));
      check({name, "_tx"}, 128'({tx_index, tx_arg}), 128'(0));
      check({name, "_resp"}, 128'(resp_data), 128'(0));
   endtask

   function automatic vec_t mk(input logic [1:0] rtype, input logic [5:0] index,
                               input logic [31:0] arg, input int start,
                               input logic [3:0] crc, input logic [1:0] st,
                               input logic [1:0] att, input int ntx,
                               input int nabort, input int lat, input bit norecv);
      vec_t v;
      v.rtype = rtype; v.index = index; v.arg = arg; v.start = start;
      v.crc = crc; v.st = st; v.att = att; v.ntx = ntx;
      v.nabort = nabort; v.lat = lat; v.norecv = norecv;
      return v;
   endfunction

   // Transmitter/receiver model plus output monitor and scoreboard.
   // Inputs are set at the falling edge for the current cycle; the
   // combinational rx_abort is sampled 1 time unit later.
   initial begin : responder
      int           tx_wait;
      int           ws;
      int           rx_cnt;
      int           cyc;
      int           last_evt;
      int           att;
      int           n_tx;
      int           n_abort;
      int           n_recv;
      int           r23_bad;
      bit           prev_fin;
      logic [127:0] rnd;
      vec_t         e;
      tx_wait = 0; ws = 0; rx_cnt = 0; cyc = 0; last_evt = 0;
      n_tx = 0; n_abort = 0; n_recv = 0; r23_bad = 0; prev_fin = 0;
      forever begin
         @(negedge sd_clk);
         cyc++;
         tx_done = 1'b0;
         rx_started = 1'b0;
         rx_finished = 1'b0;
         crc_err = 1'b0;
         if (!reset) begin
            tx_wait = 0; ws = 0; rx_cnt = 0; in_rx = 0; prev_fin = 0;
            n_tx = 0; n_abort = 0; n_recv = 0; r23_bad = 0;
            model_resp = '0;
         end else begin
            if (prev_fin) check("rx_en_fall", 128'(receive_en), 128'(0));
            prev_fin = 0;
            if (done) begin
               if (sb.size() == 0) begin
                  check("sb_nonempty_at_done", 128'(sb.size()), 128'(1));
               end else begin
                  e = sb.pop_front();
                  check("status", 128'(status), 128'(e.st));
                  check("attempts", 128'(attempts), 128'(e.att));
                  check("resp_data", 128'(resp_data), 128'(model_resp));
                  check("tx_held", 128'({tx_index, tx_arg}), 128'({e.index, e.arg}));
                  check("n_tx_start", 128'(n_tx), 128'(e.ntx));
                  check("n_rx_abort", 128'(n_abort), 128'(e.nabort));
                  check("done_latency", 128'(cyc - last_evt), 128'(e.lat));
                  check("r2_r3_decode", 128'(r23_bad), 128'(0));
                  if (e.norecv) check("no_receive_en", 128'(n_recv), 128'(0));
               end
               n_tx = 0; n_abort = 0; n_recv = 0; r23_bad = 0;
               done_cnt++;
            end
            if (busy && sb.size() != 0) begin
               if (R2_response !== (sb[0].rtype == 2'd2) ||
                   R3_response !== (sb[0].rtype == 2'd3)) r23_bad++;
            end
            if (tx_start) begin
               n_tx++;
               tx_wait = TX_LAT;
            end else if (tx_wait > 0) begin
               tx_wait--;
               if (tx_wait == 0) begin
                  tx_done = 1'b1;
                  last_evt = cyc;
               end
            end
            if (receive_en) begin
               n_recv++;
               if (!in_rx) begin
                  ws++;
                  if (ws == cfg_start) begin
                     rx_started = 1'b1;
                     in_rx = 1;
                     rx_cnt = 0;
                  end
               end else begin
                  rx_cnt++;
                  if (rx_cnt == RX_LEN) begin
                     att = (n_tx > 0) ? n_tx - 1 : 0;
                     if (att > 3) att = 3;
                     rnd = {$urandom, $urandom, $urandom, $urandom};
                     rx_response = rnd[126:0];
                     model_resp = rnd[126:0];
                     crc_err = cfg_crc[att];
                     rx_finished = 1'b1;
                     last_evt = cyc;
                     prev_fin = 1;
                  end
               end
            end else begin
               ws = 0;
               in_rx = 0;
            end
            #1;
            if (rx_abort) begin
               n_abort++;
               check("abort_cycle", 128'(ws), 128'(TMO));
               last_evt = cyc;
            end
         end
      end
   end

   initial begin : main
      int d0;
      int k;
      vec_t v;

      vecs[0] = mk(2'd1, 6'd17, 32'h0000_1234, 10, 4'b0000, 2'b00, 2'd0, 1, 0, 2, 0);
      vecs[1] = mk(2'd0, 6'd0,  32'h0000_0000, 0,  4'b0000, 2'b00, 2'd0, 1, 0, 2, 1);
`ifdef SD_CMD_RETRY_EN
      vecs[2] = mk(2'd1, 6'd8,  32'hDEAD_BEEF, 0,  4'b0000, 2'b10, 2'd2, 3, 3, 3, 0);
      vecs[3] = mk(2'd2, 6'd2,  32'h0000_0000, 7,  4'b0001, 2'b00, 2'd1, 2, 0, 2, 0);
      vecs[7] = mk(2'd2, 6'd9,  32'h1357_9BDF, 4,  4'b1111, 2'b01, 2'd2, 3, 0, 3, 0);
`else
      vecs[2] = mk(2'd1, 6'd8,  32'hDEAD_BEEF, 0,  4'b0000, 2'b10, 2'd0, 1, 1, 3, 0);
      vecs[3] = mk(2'd2, 6'd2,  32'h0000_0000, 7,  4'b0001, 2'b01, 2'd0, 1, 0, 3, 0);
      vecs[7] = mk(2'd2, 6'd9,  32'h1357_9BDF, 4,  4'b1111, 2'b01, 2'd0, 1, 0, 3, 0);
`endif
      vecs[4] = mk(2'd3, 6'd41, 32'h00FF_8000, 3,  4'b1111, 2'b00, 2'd0, 1, 0, 2, 0);
      vecs[5] = mk(2'd1, 6'd13, 32'hA5A5_0001, TMO, 4'b0000, 2'b00, 2'd0, 1, 0, 2, 0);
      vecs[6] = mk(2'd1, 6'd55, 32'h0000_0001, 1,  4'b0000, 2'b00, 2'd0, 1, 0, 2, 0);

      reset = 1'b0;
      repeat (3) @(negedge sd_clk);
      #2;
      check_reset_vals("reset");
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         cfg_start = v.start;
         cfg_crc = v.crc;
         for (int w = 0; w < 50; w++) begin
            @(negedge sd_clk); #2;
            if (req_ready) break;
         end
         check("req_ready_wait", 128'(req_ready), 128'(1));
         d0 = done_cnt;
         req_valid = 1'b1;
         req_index = v.index;
         req_arg = v.arg;
         req_resp_type = v.rtype;
         sb.push_back(v);
         @(negedge sd_clk); #2;
         req_valid = 1'b0;
         check("req_ready_fall", 128'(req_ready), 128'(0));
         for (int w = 0; w < 2000; w++) begin
            if (done_cnt != d0) break;
            @(negedge sd_clk); #2;
         end
         check("done_wait", 128'(done_cnt), 128'(d0 + 1));
      end

      // Held req_valid: re-acceptance spacing, then reset during RECEIVE.
      v = mk(2'd3, 6'd5, 32'h0BAD_F00D, 5, 4'b1111, 2'b00, 2'd0, 1, 0, 2, 0);
      cfg_start = v.start;
      cfg_crc = v.crc;
      for (int w = 0; w < 50; w++) begin
         @(negedge sd_clk); #2;
         if (req_ready) break;
      end
      d0 = done_cnt;
      req_valid = 1'b1;
      req_index = v.index;
      req_arg = v.arg;
      req_resp_type = v.rtype;
      sb.push_back(v);
      for (int w = 0; w < 500; w++) begin
         @(negedge sd_clk); #2;
         if (done_cnt != d0) break;
      end
      check("held_done", 128'(done_cnt), 128'(d0 + 1));
      k = 0;
      for (int w = 0; w < 30; w++) begin
         @(negedge sd_clk); #2;
         k++;
         if (tx_start) break;
      end
      check("reaccept_gap", 128'(k), 128'(GAP + 1));
      req_valid = 1'b0;
      for (int w = 0; w < 200; w++) begin
         @(negedge sd_clk); #2;
         if (in_rx) break;
      end
      @(negedge sd_clk); #2;
      check("in_receive", 128'({receive_en, R3_response}), 128'(2'b11));
      d0 = done_cnt;
      reset = 1'b0;
      #1;
      check_reset_vals("mid_rx_reset");
      repeat (3) @(negedge sd_clk);
      #2;
      reset = 1'b1;
      repeat (40) @(negedge sd_clk);
      #2;
      check("no_done_after_reset", 128'(done_cnt), 128'(d0));
      check("idle_after_reset", 128'({req_ready, busy}), 128'(2'b10));
      check("sb_drained", 128'(sb.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
